// File: rtl/register_16_pkg.sv
// register_16_pkg: shared CPU datapath constants (WORD_WIDTH) and the word_t type
package register_16_pkg;
  localparam int WORD_WIDTH = 16;
  typedef logic [WORD_WIDTH-1:0] word_t;
endpackage

// File: rtl/register_16_bit_cell.sv
// bit_cell: one storage bit with hold/load mux; ports clk, rst_n (async low), in, load, rst_val (reset level), out (flop)
module bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  input  logic load,
  input  logic rst_val,
  output logic out
);
  logic out_d, out_q;
  always_comb out_d = load ? in : out_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_q <= rst_val;
    else        out_q <= out_d;
  assign out = out_q;
endmodule

// File: rtl/register_16.sv
// register_16: WIDTH-bit load-enabled register of bit_cells; ports clk, rst_n (async low), in, load, out (flops, RESET_VALUE on reset)
module register_16
  import register_16_pkg::*;
#(
  parameter int               WIDTH       = WORD_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bit_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in[i]),
      .load   (load),
      .rst_val(RESET_VALUE[i]),
      .out    (out[i])
    );
  end
endmodule

// File: tb/tb_register_16.sv
// tb_register_16: directed scoreboard bench for register_16 at default width and at WIDTH=8/RESET_VALUE=8'hA5
module tb_register_16;
  import register_16_pkg::*;
  typedef struct {
    string        tag;
    logic  [15:0] exp;
    bit           narrow;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load = 1'b0;
  word_t      in = '0;
  word_t      out16;
  logic [7:0] out8;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  register_16 u_dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .load (load),
    .out  (out16)
  );
  register_16 #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in[7:0]),
    .load (load),
    .out  (out8)
  );
  task automatic expect_val(input string tag, input logic [15:0] exp, input bit narrow = 1'b0);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    e.narrow = narrow;
    sb.push_back(e);
  endtask
  task automatic check_next();
    exp_t        e;
    logic [15:0] obs;
    e = sb.pop_front();
    obs = e.narrow ? {8'h00, out8} : out16;
    checks++;
    assert (obs === e.exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    load = 1'b1;
    in = 16'hFFFF;
    #2 rst_n = 1'b0;
    #1;
    expect_val("rst_async", 16'h0000);
    check_next();
    expect_val("rst_async_w8", 16'h00A5, 1'b1);
    check_next();
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      expect_val("rst_held", 16'h0000);
      check_next();
      expect_val("rst_held_w8", 16'h00A5, 1'b1);
      check_next();
    end
    @(negedge clk);
    rst_n = 1'b1;
    load = 1'b0;
    in = 16'h00FF;
    edge_sample();
    expect_val("hold", 16'h0000);
    check_next();
    @(negedge clk);
    load = 1'b1;
    #1;
    expect_val("load_before_edge", 16'h0000);
    check_next();
    edge_sample();
    expect_val("load", 16'h00FF);
    check_next();
    expect_val("load_w8", 16'h00FF, 1'b1);
    check_next();
    @(negedge clk);
    in = 16'hAAAA;
    edge_sample();
    expect_val("back_to_back", 16'hAAAA);
    check_next();
    @(negedge clk);
    load = 1'b0;
    in = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      expect_val("hold_3", 16'hAAAA);
      check_next();
    end
    @(negedge clk);
    load = 1'b1;
    in = 16'h1111;
    #1;
    expect_val("glitch_a", 16'hAAAA);
    check_next();
    in = 16'h2222;
    #1;
    expect_val("glitch_b", 16'hAAAA);
    check_next();
    in = 16'h1234;
    edge_sample();
    expect_val("glitch_settle", 16'h1234);
    check_next();
    expect_val("glitch_settle_w8", 16'h0034, 1'b1);
    check_next();
    @(negedge clk);
    load = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    expect_val("async_mid", 16'h0000);
    check_next();
    expect_val("async_mid_w8", 16'h00A5, 1'b1);
    check_next();
    #1 rst_n = 1'b1;
    @(negedge clk);
    load = 1'b1;
    in = 16'hBEEF;
    edge_sample();
    expect_val("first_edge_after_release", 16'hBEEF);
    check_next();
    expect_val("first_edge_after_release_w8", 16'h00EF, 1'b1);
    check_next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
